// File: rtl/chip8_keypad_pkg.sv
// rtl/chip8_keypad_pkg.sv - shared types, helpers and constants for the keypad scanner
package chip8_keypad_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        SAMPLE = 1'b1
    } scan_state_e;

    localparam int KEY_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             pressed;
    } key_evt_t;

    // Physical key index: rows are major, columns minor.
    function automatic int key_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

    // Physical 4x4 position -> CHIP-8 hex key (123C/456D/789E/A0BF layout); used downstream only.
    localparam logic [3:0] HEX_REMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

endpackage

// File: rtl/chip8_key_debounce.sv
// rtl/chip8_key_debounce.sv - one key's debounced bit; counter present only with CHIP8_KEYPAD_DEBOUNCE_EN
module chip8_key_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sample_en_in,
    input  logic raw_in,
    output logic db_next_out
);

    logic db_q, db_d;

`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
    localparam int CNTW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNTW-1:0] CNT_FLIP = CNTW'(DEBOUNCE_SCANS - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; the DEBOUNCE_SCANS-th one flips the bit.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sample_en_in) begin
            if (raw_in == db_q) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_FLIP) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Disagreement counter register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_debounce_scans;
    assign unused_debounce_scans = (DEBOUNCE_SCANS > 0);

    // Without debouncing the stored bit simply follows each raw sample.
    always_comb begin
        db_d = sample_en_in ? raw_in : db_q;
    end
`endif

    // Debounced bit register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            db_q <= 1'b0;
        end else begin
            db_q <= db_d;
        end
    end

    // Includes this cycle's update so the snapshot can capture it in the same edge.
    assign db_next_out = db_d;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// rtl/chip8_keypad_scanner.sv - matrix keypad scanner with per-scan snapshot and event stream (debounce: CHIP8_KEYPAD_DEBOUNCE_EN)
module chip8_keypad_scanner
    import chip8_keypad_pkg::*;
#(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int SETTLE_CYCLES  = 3,
    parameter  int DEBOUNCE_SCANS = 4,
    localparam int N              = ROWS * COLS,
    localparam int IW             = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [ROWS-1:0] row_vals,
    output logic [COLS-1:0] col_vals,
    output logic [N-1:0]    key_state_out,
    output logic            scan_done_out,
    output logic            evt_valid_out,
    input  logic            evt_ready_in,
    output logic [IW-1:0]   evt_key_out,
    output logic            evt_pressed_out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

    logic            started_q, started_d;
    scan_state_e     state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    // Sync flops hold inverted pins: 1 = switch closed, reset value reads as idle.
    logic [ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]    key_state_q, key_state_d;
    logic            scan_done_q, scan_done_d;
    logic [N-1:0]    reported_q, reported_d;
    logic            evt_valid_q, evt_valid_d;
    logic [IW-1:0]   evt_key_q, evt_key_d;
    logic            evt_pressed_q, evt_pressed_d;
    logic [COLS-1:0] sample_col;
    logic [N-1:0]    db_next;

    // Drive only after the first post-reset edge; all columns idle high before that.
    assign col_vals   = started_q ? ~(COLS'(1) << col_q) : '1;
    assign sample_col = (state_q == SAMPLE) ? (COLS'(1) << col_q) : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = key_idx(r, c, COLS);
            chip8_key_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_key (
                .clk_in       (clk_in),
                .rst_n_in     (rst_n_in),
                .sample_en_in (sample_col[c]),
                .raw_in       (sync2_q[r]),
                .db_next_out  (db_next[K])
            );
        end
    end

    // Scan sequencing: settle counter, column advance, row sync and snapshot commit.
    always_comb begin
        started_d   = 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        sync1_d     = ~row_vals;
        sync2_d     = sync1_q;
        key_state_d = key_state_q;
        scan_done_d = 1'b0;
        if (started_q) begin
            unique case (state_q)
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    state_d = SETTLE;
                    if (col_q == COL_LAST) begin
                        col_d       = '0;
                        key_state_d = db_next;
                        scan_done_d = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Event stream: deliver the lowest differing key; a loaded event holds until accepted.
    always_comb begin
        reported_d    = reported_q;
        evt_valid_d   = evt_valid_q;
        evt_key_d     = evt_key_q;
        evt_pressed_d = evt_pressed_q;
        if (evt_valid_q) begin
            if (evt_ready_in) begin
                reported_d[evt_key_q] = evt_pressed_q;
                evt_valid_d           = 1'b0;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (key_state_q[i] != reported_q[i]) begin
                    evt_key_d     = IW'(i);
                    evt_pressed_d = key_state_q[i];
                    evt_valid_d   = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            started_q     <= 1'b0;
            state_q       <= SETTLE;
            cnt_q         <= '0;
            col_q         <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            key_state_q   <= '0;
            scan_done_q   <= 1'b0;
            reported_q    <= '0;
            evt_valid_q   <= 1'b0;
            evt_key_q     <= '0;
            evt_pressed_q <= 1'b0;
        end else begin
            started_q     <= started_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            key_state_q   <= key_state_d;
            scan_done_q   <= scan_done_d;
            reported_q    <= reported_d;
            evt_valid_q   <= evt_valid_d;
            evt_key_q     <= evt_key_d;
            evt_pressed_q <= evt_pressed_d;
        end
    end

    assign key_state_out   = key_state_q;
    assign scan_done_out   = scan_done_q;
    assign evt_valid_out   = evt_valid_q;
    assign evt_key_out     = evt_key_q;
    assign evt_pressed_out = evt_pressed_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// tb/tb_chip8_keypad_scanner.sv - directed vector bench for chip8_keypad_scanner (CHIP8_KEYPAD_DEBOUNCE_EN aware)
module tb_chip8_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [15:0] keys;
        logic [15:0] exp;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [3:0]  row_vals;
    logic [3:0]  col_vals;
    logic [15:0] key_state_out;
    logic        scan_done_out;
    logic        evt_valid_out;
    logic        evt_ready_in = 1'b0;
    logic [3:0]  evt_key_out;
    logic        evt_pressed_out;
    logic [15:0] keys = '0;
    int          n_pass = 0;
    int          n_total = 0;
    logic        mon_valid;
    logic        mon_k6;

    always #5 clk_in = ~clk_in;

    chip8_keypad_scanner dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .row_vals        (row_vals),
        .col_vals        (col_vals),
        .key_state_out   (key_state_out),
        .scan_done_out   (scan_done_out),
        .evt_valid_out   (evt_valid_out),
        .evt_ready_in    (evt_ready_in),
        .evt_key_out     (evt_key_out),
        .evt_pressed_out (evt_pressed_out)
    );

    // Passive matrix: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        row_vals = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !col_vals[c]) row_vals[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_scan(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (scan_done_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_event(output logic [3:0] k, output logic p, output bit ok);
        ok = 1'b0;
        k  = '0;
        p  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (evt_valid_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (ok) begin
            k = evt_key_out;
            p = evt_pressed_out;
            evt_ready_in = 1'b1;
            @(negedge clk_in);
            evt_ready_in = 1'b0;
        end
    endtask

    task automatic mon_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (evt_valid_out) mon_valid = 1'b1;
            if (key_state_out[6]) mon_k6 = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [15:0] exp, output int nscan, output bit hit);
        bit ok;
        hit   = 1'b0;
        nscan = 0;
        for (int s = 0; s < LAT + 3; s++) begin
            wait_scan(ok);
            nscan++;
            if (ok && key_state_out == exp) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t        tbl [8];
        bit          ok, hit, stable, any_done;
        logic [3:0]  k, expc;
        logic        p;
        logic [15:0] prev, diff, expv;
        int          cnt, nscan;

        tbl[0] = '{16'h0040, 16'h0040};
        tbl[1] = '{16'h0000, 16'h0000};
        tbl[2] = '{16'h0001, 16'h0001};
        tbl[3] = '{16'h8000, 16'h8000};
        tbl[4] = '{16'h00F0, 16'h00F0};
        tbl[5] = '{16'h2222, 16'h2222};
        tbl[6] = '{16'hFFFF, 16'hFFFF};
        tbl[7] = '{16'h0000, 16'h0000};

        repeat (3) @(negedge clk_in);
        chk("rst_col", col_vals, 4'hF);
        chk("rst_state", key_state_out, 0);
        chk("rst_done", scan_done_out, 0);
        chk("rst_valid", evt_valid_out, 0);
        chk("rst_key", evt_key_out, 0);
        chk("rst_pressed", evt_pressed_out, 0);

        rst_n_in  = 1'b1;
        mon_valid = 1'b0;
        mon_k6    = 1'b0;
        any_done  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            if (scan_done_out) any_done = 1'b1;
            if (evt_valid_out) mon_valid = 1'b1;
            expc = ~(4'b0001 << (i / 4));
            chk($sformatf("col_seq%0d", i), col_vals, expc);
        end
        chk("early_done", any_done, 0);
        @(negedge clk_in);
        chk("first_done", scan_done_out, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            cnt++;
            if (evt_valid_out) mon_valid = 1'b1;
            if (scan_done_out) break;
        end
        chk("scan_period", cnt, 16);
        chk("idle_no_evt", mon_valid, 0);

        prev = '0;
        for (int v = 0; v < 8; v++) begin
            wait_scan(ok);
            chk($sformatf("v%0d_sync", v), ok, 1);
            keys = tbl[v].keys;
            wait_state(tbl[v].exp, nscan, hit);
            chk($sformatf("v%0d_state", v), key_state_out, tbl[v].exp);
            chk($sformatf("v%0d_scans", v), nscan, LAT);
            chk($sformatf("v%0d_valid_lo", v), evt_valid_out, 0);
            @(negedge clk_in);
            chk($sformatf("v%0d_valid_rise", v), evt_valid_out, 1);
            diff = prev ^ tbl[v].exp;
            expv = tbl[v].exp;
            for (int i = 0; i < 16; i++) begin
                if (diff[i]) begin
                    get_event(k, p, ok);
                    chk($sformatf("v%0d_evt%0d_seen", v, i), ok, 1);
                    chk($sformatf("v%0d_evt%0d_key", v, i), k, i);
                    chk($sformatf("v%0d_evt%0d_pressed", v, i), p, expv[i]);
                    chk($sformatf("v%0d_evt%0d_gap", v, i), evt_valid_out, 0);
                end
            end
            mon_valid = 1'b0;
            mon_cycles(20);
            chk($sformatf("v%0d_no_extra", v), mon_valid, 0);
            prev = tbl[v].exp;
        end

        // Keys 3 and 9 together, consumer stalled.
        wait_scan(ok);
        keys = 16'h0208;
        wait_state(16'h0208, nscan, hit);
        chk("h2_state", hit, 1);
        @(negedge clk_in);
        chk("h2_valid", evt_valid_out, 1);
        chk("h2_key", evt_key_out, 3);
        chk("h2_pressed", evt_pressed_out, 1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (!evt_valid_out || evt_key_out != 4'd3 || !evt_pressed_out) stable = 1'b0;
        end
        chk("h2_hold", stable, 1);
        evt_ready_in = 1'b1;
        @(negedge clk_in);
        evt_ready_in = 1'b0;
        chk("h2_gap", evt_valid_out, 0);
        get_event(k, p, ok);
        chk("h2_second_seen", ok, 1);
        chk("h2_second_key", k, 9);
        chk("h2_second_pressed", p, 1);

        // Key 9 drops and returns while the key-3 release event waits: no key-9 event.
        wait_scan(ok);
        keys = 16'h0200;
        wait_state(16'h0200, nscan, hit);
        chk("h3_state", hit, 1);
        @(negedge clk_in);
        chk("h3_valid", evt_valid_out, 1);
        keys = 16'h0000;
        wait_state(16'h0000, nscan, hit);
        chk("h3_k9_off", hit, 1);
        keys = 16'h0200;
        wait_state(16'h0200, nscan, hit);
        chk("h3_k9_on", hit, 1);
        chk("h3_key", evt_key_out, 3);
        chk("h3_pressed", evt_pressed_out, 0);
        evt_ready_in = 1'b1;
        @(negedge clk_in);
        evt_ready_in = 1'b0;
        mon_valid = 1'b0;
        mon_cycles(40);
        chk("h3_no_k9_evt", mon_valid, 0);

`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
        // Bouncing key 6: closed two scans, open one, never reaches the threshold.
        wait_scan(ok);
        mon_valid = 1'b0;
        mon_k6    = 1'b0;
        for (int rep = 0; rep < 4; rep++) begin
            keys = 16'h0240;
            mon_cycles(32);
            keys = 16'h0200;
            mon_cycles(16);
        end
        chk("h4_bounce_state", mon_k6, 0);
        chk("h4_bounce_evt", mon_valid, 0);
`endif

        // Reset mid-settle with an event pending.
        wait_scan(ok);
        keys = 16'h0040;
        wait_state(16'h0040, nscan, hit);
        chk("h5_state", hit, 1);
        @(negedge clk_in);
        chk("h5_valid", evt_valid_out, 1);
        chk("h5_key", evt_key_out, 6);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("h5_rst_col", col_vals, 4'hF);
        chk("h5_rst_state", key_state_out, 0);
        chk("h5_rst_done", scan_done_out, 0);
        chk("h5_rst_valid", evt_valid_out, 0);
        chk("h5_rst_key", evt_key_out, 0);
        chk("h5_rst_pressed", evt_pressed_out, 0);
        keys = 16'h0000;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("h5_col0_first", col_vals, 4'hE);
        repeat (3) @(negedge clk_in);
        chk("h5_col0_hold", col_vals, 4'hE);
        @(negedge clk_in);
        chk("h5_col1", col_vals, 4'hD);
        mon_valid = 1'b0;
        mon_cycles(48);
        chk("h5_discarded", mon_valid, 0);
        chk("h5_state_after", key_state_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
